regfile_scoreboard: RTL and testbench

- Parametrised two-read/one-write register file for the single-cycle datapath and its planned pipelined successor.
- Generalises data width and register count, and adds an optional hardwired zero register and write-to-read bypass.
- Adds a per-register busy scoreboard. The issue stage reserves a destination, writeback clears it, and a flush clears every reservation. Decode uses the busy flags to stall on RAW hazards.

---
 rtl/regfile_scoreboard.sv | 104 ++++++++++
 tb/tb_regfile_scoreboard.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// regfile_scoreboard : 2R/1W register file with write-through bypass and a
//                      per-register busy scoreboard for RAW/WAW stalls.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_scoreboard #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ZERO_REG = 0,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ack,
  input  logic              flush,
  output logic [ADDR_W:0]   busy_cnt
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [ADDR_W:0]     busy_cnt_q;
  logic [ADDR_W:0]     busy_cnt_d;

  logic zero1, zero2, zero_wr, zero_rsv;
  logic byp1, byp2, wr_hits_rsv;

  always_comb begin
    zero1    = (ZERO_REG != 0) && (rd_addr1 == '0);
    zero2    = (ZERO_REG != 0) && (rd_addr2 == '0);
    zero_wr  = (ZERO_REG != 0) && (wr_addr == '0);
    zero_rsv = (ZERO_REG != 0) && (rsv_addr == '0);
    byp1     = wr_en && (wr_addr == rd_addr1);
    byp2     = wr_en && (wr_addr == rd_addr2);
    wr_hits_rsv = wr_en && (wr_addr == rsv_addr);
  end

  // Hardwired zero register wins over the bypass path.
  always_comb begin
    rd_data1 = zero1 ? '0 : (byp1 ? wr_data : regs_q[rd_addr1]);
    rd_data2 = zero2 ? '0 : (byp2 ? wr_data : regs_q[rd_addr2]);
    rd_busy1 = !zero1 && busy_q[rd_addr1] && !byp1;
    rd_busy2 = !zero2 && busy_q[rd_addr2] && !byp2;
    rsv_ack  = rsv_en && !flush && rst &&
               (zero_rsv || !busy_q[rsv_addr] || wr_hits_rsv);
  end

  // Writeback clears before reserve sets, so a same-address reserve wins.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_en && !zero_wr) begin
      regs_d[wr_addr] = wr_data;
    end
    if (wr_en) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (flush) begin
      busy_d = '0;
    end else if (rsv_ack && !zero_rsv) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  always_comb begin
    busy_cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_cnt_d = busy_cnt_d + (ADDR_W + 1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// ============================================================================
// tb_regfile_scoreboard : directed + randomized checks of two configurations
//                         (16x16 plain, 32x32 with hardwired zero register).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfile_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic we [2];
  logic rsv_e [2];
  logic fl [2];
  logic [4:0]  wa [2];
  logic [4:0]  ra1 [2];
  logic [4:0]  ra2 [2];
  logic [4:0]  rsv_a [2];
  logic [31:0] wd [2];

  logic [15:0] a_rd1, a_rd2;
  logic [31:0] b_rd1, b_rd2;
  logic a_rb1, a_rb2, a_ack, b_rb1, b_rb2, b_ack;
  logic [4:0] a_cnt;
  logic [5:0] b_cnt;

  logic [31:0] mem [2][32];
  bit          busy [2][32];

  int n_checks = 0;
  int n_pass   = 0;

  regfile_scoreboard #(.DATA_W(16), .NUM_REGS(16), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst(rst),
    .rd_addr1(ra1[0][3:0]), .rd_addr2(ra2[0][3:0]),
    .rd_data1(a_rd1), .rd_data2(a_rd2),
    .rd_busy1(a_rb1), .rd_busy2(a_rb2),
    .wr_en(we[0]), .wr_addr(wa[0][3:0]), .wr_data(wd[0][15:0]),
    .rsv_en(rsv_e[0]), .rsv_addr(rsv_a[0][3:0]), .rsv_ack(a_ack),
    .flush(fl[0]), .busy_cnt(a_cnt)
  );

  regfile_scoreboard #(.DATA_W(32), .NUM_REGS(32), .ZERO_REG(1)) dut1 (
    .clk(clk), .rst(rst),
    .rd_addr1(ra1[1]), .rd_addr2(ra2[1]),
    .rd_data1(b_rd1), .rd_data2(b_rd2),
    .rd_busy1(b_rb1), .rd_busy2(b_rb2),
    .wr_en(we[1]), .wr_addr(wa[1]), .wr_data(wd[1]),
    .rsv_en(rsv_e[1]), .rsv_addr(rsv_a[1]), .rsv_ack(b_ack),
    .flush(fl[1]), .busy_cnt(b_cnt)
  );

  function automatic logic [31:0] o_rd(int k, int p);
    if (k == 0) return (p == 1) ? {16'h0, a_rd1} : {16'h0, a_rd2};
    return (p == 1) ? b_rd1 : b_rd2;
  endfunction

  function automatic logic o_rb(int k, int p);
    if (k == 0) return (p == 1) ? a_rb1 : a_rb2;
    return (p == 1) ? b_rb1 : b_rb2;
  endfunction

  function automatic logic o_ack(int k);
    return (k == 0) ? a_ack : b_ack;
  endfunction

  function automatic logic [31:0] o_cnt(int k);
    return (k == 0) ? {27'h0, a_cnt} : {26'h0, b_cnt};
  endfunction

  // Reference model: the visible rules of the register file, stated directly.
  function automatic logic [31:0] m_rd(int k, logic [4:0] a);
    if (k == 1 && a == 0) return 32'h0;
    if (we[k] && wa[k] == a) return wd[k];
    return mem[k][a];
  endfunction

  function automatic logic m_rb(int k, logic [4:0] a);
    if (k == 1 && a == 0) return 1'b0;
    return busy[k][a] && !(we[k] && wa[k] == a);
  endfunction

  function automatic logic m_ack(int k);
    return rsv_e[k] && !fl[k] && rst &&
           (!busy[k][rsv_a[k]] || (we[k] && wa[k] == rsv_a[k]));
  endfunction

  function automatic logic [31:0] m_cnt(int k);
    int c = 0;
    foreach (busy[k][i]) c += busy[k][i] ? 1 : 0;
    return 32'(c);
  endfunction

  task automatic m_clear(int k);
    for (int i = 0; i < 32; i++) begin
      mem[k][i]  = 32'h0;
      busy[k][i] = 1'b0;
    end
  endtask

  task automatic m_edge(int k);
    logic ack;
    ack = m_ack(k);
    if (we[k] && !(k == 1 && wa[k] == 0)) mem[k][wa[k]] = wd[k];
    if (we[k]) busy[k][wa[k]] = 1'b0;
    if (fl[k]) begin
      for (int i = 0; i < 32; i++) busy[k][i] = 1'b0;
    end else if (ack && !(k == 1 && rsv_a[k] == 0)) begin
      busy[k][rsv_a[k]] = 1'b1;
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_comb(int k);
    check($sformatf("rd1_i%0d_a%0d", k, ra1[k]), o_rd(k, 1), m_rd(k, ra1[k]));
    check($sformatf("rd2_i%0d_a%0d", k, ra2[k]), o_rd(k, 2), m_rd(k, ra2[k]));
    check($sformatf("rb1_i%0d_a%0d", k, ra1[k]), 32'(o_rb(k, 1)), 32'(m_rb(k, ra1[k])));
    check($sformatf("rb2_i%0d_a%0d", k, ra2[k]), 32'(o_rb(k, 2)), 32'(m_rb(k, ra2[k])));
    check($sformatf("ack_i%0d", k), 32'(o_ack(k)), 32'(m_ack(k)));
  endtask

  // Inputs are applied at posedge+1; outputs are checked mid-cycle and after the edge.
  task automatic cycle();
    #1;
    check_comb(0);
    check_comb(1);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) m_edge(k);
      else m_clear(k);
    end
    #1;
    check("cnt_i0", o_cnt(0), m_cnt(0));
    check("cnt_i1", o_cnt(1), m_cnt(1));
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      we[k] = 1'b0; rsv_e[k] = 1'b0; fl[k] = 1'b0;
      wa[k] = '0; ra1[k] = '0; ra2[k] = '0; rsv_a[k] = '0; wd[k] = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    idle();
    m_clear(0);
    m_clear(1);
    #2;
    check("rst_cnt0", o_cnt(0), 32'h0);
    check("rst_rd0", o_rd(0, 1), 32'h0);
    check_comb(0);
    check_comb(1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Basic writes and reads
    we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'h1234;
    cycle();
    wa[0] = 5'd9; wd[0] = 32'hBEEF;
    cycle();
    idle(); ra1[0] = 5'd3; ra2[0] = 5'd9;
    #1;
    check("r3", o_rd(0, 1), 32'h1234);
    check("r9", o_rd(0, 2), 32'hBEEF);
    cycle();
    for (int a = 0; a < 16; a++) begin
      ra1[0] = 5'(a); ra2[0] = 5'(15 - a);
      cycle();
    end

    // Bypass
    idle(); we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'h0001;
    cycle();
    wd[0] = 32'hA5A5; ra1[0] = 5'd5; ra2[0] = 5'd5;
    #1;
    check("byp_pre1", o_rd(0, 1), 32'hA5A5);
    check("byp_pre2", o_rd(0, 2), 32'hA5A5);
    cycle();
    idle(); ra1[0] = 5'd5; ra2[0] = 5'd5;
    #1;
    check("byp_post", o_rd(0, 1), 32'hA5A5);
    cycle();

    // Scoreboard reserve / re-reserve / writeback
    idle(); rsv_e[0] = 1'b1; rsv_a[0] = 5'd7;
    #1;
    check("rsv7_ack", 32'(a_ack), 32'h1);
    cycle();
    idle(); ra1[0] = 5'd7;
    #1;
    check("r7_busy", 32'(a_rb1), 32'h1);
    check("cnt_1", o_cnt(0), 32'h1);
    rsv_e[0] = 1'b1; rsv_a[0] = 5'd7;
    #1;
    check("rsv7_waw", 32'(a_ack), 32'h0);
    cycle();
    idle(); ra1[0] = 5'd7; we[0] = 1'b1; wa[0] = 5'd7; wd[0] = 32'h0042;
    #1;
    check("r7_wb_busy", 32'(a_rb1), 32'h0);
    cycle();
    check("cnt_0", o_cnt(0), 32'h0);

    // Simultaneous write and reserve
    idle(); rsv_e[0] = 1'b1; rsv_a[0] = 5'd2;
    cycle();
    we[0] = 1'b1; wa[0] = 5'd2; wd[0] = 32'h00FF;
    #1;
    check("sim_ack", 32'(a_ack), 32'h1);
    cycle();
    idle(); ra1[0] = 5'd2;
    #1;
    check("sim_data", o_rd(0, 1), 32'h00FF);
    check("sim_busy", 32'(a_rb1), 32'h1);
    check("sim_cnt", o_cnt(0), 32'h1);
    we[0] = 1'b1; wa[0] = 5'd2; wd[0] = 32'h00FF;
    cycle();

    // Flush
    idle(); rsv_e[0] = 1'b1;
    rsv_a[0] = 5'd1; cycle();
    rsv_a[0] = 5'd4; cycle();
    rsv_a[0] = 5'd6; cycle();
    check("flush_pre_cnt", o_cnt(0), 32'h3);
    rsv_a[0] = 5'd8; fl[0] = 1'b1;
    #1;
    check("flush_ack", 32'(a_ack), 32'h0);
    cycle();
    check("flush_cnt", o_cnt(0), 32'h0);
    idle();
    for (int a = 0; a < 16; a++) begin
      ra1[0] = 5'(a); ra2[0] = 5'(a ^ 1);
      cycle();
    end

    // Asynchronous reset mid-operation
    idle(); we[0] = 1'b1; wa[0] = 5'd10; wd[0] = 32'h0077; rsv_e[0] = 1'b1; rsv_a[0] = 5'd11;
    cycle();
    idle(); ra1[0] = 5'd10; ra2[0] = 5'd11;
    #2;
    rst = 1'b0;
    m_clear(0);
    m_clear(1);
    #1;
    check("arst_data", o_rd(0, 1), 32'h0);
    check("arst_busy", 32'(a_rb2), 32'h0);
    check("arst_cnt", o_cnt(0), 32'h0);
    rsv_e[0] = 1'b1; rsv_a[0] = 5'd3;
    cycle();
    idle();
    rst = 1'b1;
    cycle();

    // Hardwired zero register (second instance)
    idle(); we[1] = 1'b1; wa[1] = 5'd0; wd[1] = 32'hFFFFFFFF; ra1[1] = 5'd0;
    #1;
    check("z_wr_byp", o_rd(1, 1), 32'h0);
    cycle();
    idle(); ra1[1] = 5'd0; rsv_e[1] = 1'b1; rsv_a[1] = 5'd0;
    #1;
    check("z_rd", o_rd(1, 1), 32'h0);
    check("z_ack", 32'(b_ack), 32'h1);
    cycle();
    check("z_cnt", o_cnt(1), 32'h0);
    idle(); we[1] = 1'b1; wa[1] = 5'd31; wd[1] = 32'hDEADBEEF;
    cycle();
    idle(); ra1[1] = 5'd31;
    #1;
    check("r31", o_rd(1, 1), 32'hDEADBEEF);
    cycle();

    // Randomized traffic on both instances
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        int nr;
        nr = (k == 0) ? 16 : 32;
        we[k]    = ($urandom % 2) == 0;
        wa[k]    = 5'($urandom_range(nr - 1));
        wd[k]    = (k == 0) ? ($urandom & 32'hFFFF) : $urandom;
        rsv_e[k] = ($urandom % 3) != 0;
        rsv_a[k] = (($urandom % 4) == 0) ? wa[k] : 5'($urandom_range(nr - 1));
        fl[k]    = ($urandom % 16) == 0;
        ra1[k]   = (($urandom % 4) == 0) ? wa[k] : 5'($urandom_range(nr - 1));
        ra2[k]   = (($urandom % 4) == 0) ? rsv_a[k] : 5'($urandom_range(nr - 1));
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
